cdb_arbiter: RTL and testbench

CDB_ARBITER -- requirements
Module: cdb_arbiter

---
 rtl/cdb_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_cdb_arbiter.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: two result FIFOs (ALU, LSB) that share one registered broadcast port.
// Define CDB_ROUND_ROBIN_EN for round-robin grants; without it the LSB has fixed priority over the ALU.

module cdb_fifo #(
    parameter int ROB_WIDTH  = 4,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 flush_i,
    input  logic                 push_i,
    input  logic [ROB_WIDTH-1:0] rob_i,
    input  logic [31:0]          val_i,
    input  logic                 pop_i,
    output logic                 ready_o,
    output logic                 empty_o,
    output logic [ROB_WIDTH-1:0] rob_o,
    output logic [31:0]          val_o
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    logic [ROB_WIDTH-1:0] rob_mem_q [FIFO_DEPTH];
    logic [31:0]          val_mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]     count_q;

    // Ready depends on the registered count only, so a full FIFO refuses even while being popped.
    assign ready_o = (count_q < DEPTH_C) && !rst_i && !flush_i;
    assign empty_o = (count_q == '0);
    assign rob_o   = rob_mem_q[rd_ptr_q];
    assign val_o   = val_mem_q[rd_ptr_q];

    always_ff @(posedge clk_i) begin
        if (push_i) begin
            rob_mem_q[wr_ptr_q] <= rob_i;
            val_mem_q[wr_ptr_q] <= val_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end
endmodule

module cdb_arbiter #(
    parameter int ROB_WIDTH  = 4,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                 clockIn,
    input  logic                 resetIn,
    input  logic                 clear,
    input  logic                 aluValid,
    input  logic [ROB_WIDTH-1:0] aluRobIndex,
    input  logic [31:0]          aluValue,
    output logic                 aluReady,
    input  logic                 lsbValid,
    input  logic [ROB_WIDTH-1:0] lsbRobIndex,
    input  logic [31:0]          lsbValue,
    output logic                 lsbReady,
    output logic                 cdbValid,
    output logic [ROB_WIDTH-1:0] cdbRobIndex,
    output logic [31:0]          cdbValue
);
    logic                 alu_push, lsb_push;
    logic                 alu_empty, lsb_empty;
    logic                 grant_alu, grant_lsb;
    logic [ROB_WIDTH-1:0] alu_head_rob, lsb_head_rob;
    logic [31:0]          alu_head_val, lsb_head_val;

    logic                 cdb_valid_q, cdb_valid_d;
    logic [ROB_WIDTH-1:0] cdb_rob_q, cdb_rob_d;
    logic [31:0]          cdb_val_q, cdb_val_d;
    logic                 last_grant_q, last_grant_d;

    assign alu_push = aluValid && aluReady;
    assign lsb_push = lsbValid && lsbReady;

    cdb_fifo #(.ROB_WIDTH(ROB_WIDTH), .FIFO_DEPTH(FIFO_DEPTH)) u_alu_fifo (
        .clk_i   (clockIn),
        .rst_i   (resetIn),
        .flush_i (clear),
        .push_i  (alu_push),
        .rob_i   (aluRobIndex),
        .val_i   (aluValue),
        .pop_i   (grant_alu),
        .ready_o (aluReady),
        .empty_o (alu_empty),
        .rob_o   (alu_head_rob),
        .val_o   (alu_head_val)
    );

    cdb_fifo #(.ROB_WIDTH(ROB_WIDTH), .FIFO_DEPTH(FIFO_DEPTH)) u_lsb_fifo (
        .clk_i   (clockIn),
        .rst_i   (resetIn),
        .flush_i (clear),
        .push_i  (lsb_push),
        .rob_i   (lsbRobIndex),
        .val_i   (lsbValue),
        .pop_i   (grant_lsb),
        .ready_o (lsbReady),
        .empty_o (lsb_empty),
        .rob_o   (lsb_head_rob),
        .val_o   (lsb_head_val)
    );

    always_comb begin
        grant_alu = 1'b0;
        grant_lsb = 1'b0;
        if (!clear && !resetIn) begin
`ifdef CDB_ROUND_ROBIN_EN
            if (!alu_empty && !lsb_empty) begin
                grant_alu = last_grant_q;
                grant_lsb = !last_grant_q;
            end else if (!lsb_empty) begin
                grant_lsb = 1'b1;
            end else if (!alu_empty) begin
                grant_alu = 1'b1;
            end
`else
            if (!lsb_empty) begin
                grant_lsb = 1'b1;
            end else if (!alu_empty) begin
                grant_alu = 1'b1;
            end
`endif
        end
    end

    // Payload holds its last value when nothing is granted; only the valid bit drops.
    always_comb begin
        cdb_valid_d  = grant_alu || grant_lsb;
        cdb_rob_d    = cdb_rob_q;
        cdb_val_d    = cdb_val_q;
        last_grant_d = last_grant_q;
        if (grant_lsb) begin
            cdb_rob_d    = lsb_head_rob;
            cdb_val_d    = lsb_head_val;
            last_grant_d = 1'b1;
        end else if (grant_alu) begin
            cdb_rob_d    = alu_head_rob;
            cdb_val_d    = alu_head_val;
            last_grant_d = 1'b0;
        end
    end

    always_ff @(posedge clockIn) begin
        if (resetIn) begin
            cdb_valid_q  <= 1'b0;
            cdb_rob_q    <= '0;
            cdb_val_q    <= '0;
            last_grant_q <= 1'b1;
        end else if (clear) begin
            cdb_valid_q  <= 1'b0;
            last_grant_q <= 1'b1;
        end else begin
            cdb_valid_q  <= cdb_valid_d;
            cdb_rob_q    <= cdb_rob_d;
            cdb_val_q    <= cdb_val_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign cdbValid    = cdb_valid_q;
    assign cdbRobIndex = cdb_rob_q;
    assign cdbValue    = cdb_val_q;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Randomized bench for cdb_arbiter against a queue-based reference model, plus short directed scenarios.
// Honors CDB_ROUND_ROBIN_EN the same way the design does.

module tb_cdb_arbiter;
    localparam int RW    = 4;
    localparam int DEPTH = 2;

    logic          clockIn = 1'b0;
    logic          resetIn, clear;
    logic          aluValid, lsbValid;
    logic [RW-1:0] aluRobIndex, lsbRobIndex;
    logic [31:0]   aluValue, lsbValue;
    logic          aluReady, lsbReady;
    logic          cdbValid;
    logic [RW-1:0] cdbRobIndex;
    logic [31:0]   cdbValue;

    cdb_arbiter #(.ROB_WIDTH(RW), .FIFO_DEPTH(DEPTH)) dut (
        .clockIn     (clockIn),
        .resetIn     (resetIn),
        .clear       (clear),
        .aluValid    (aluValid),
        .aluRobIndex (aluRobIndex),
        .aluValue    (aluValue),
        .aluReady    (aluReady),
        .lsbValid    (lsbValid),
        .lsbRobIndex (lsbRobIndex),
        .lsbValue    (lsbValue),
        .lsbReady    (lsbReady),
        .cdbValid    (cdbValid),
        .cdbRobIndex (cdbRobIndex),
        .cdbValue    (cdbValue)
    );

    always #5 clockIn = ~clockIn;

    typedef struct packed {
        logic [RW-1:0] rob;
        logic [31:0]   val;
    } entry_t;

    entry_t        alu_q[$];
    entry_t        lsb_q[$];
    bit            m_last;
    logic          exp_valid;
    logic [RW-1:0] exp_rob;
    logic [31:0]   exp_val;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Who gets the bus this edge: 0 none, 1 ALU, 2 LSB.
    function automatic int pick();
        bit a, l;
        a = alu_q.size() > 0;
        l = lsb_q.size() > 0;
        if (!a && !l) return 0;
`ifdef CDB_ROUND_ROBIN_EN
        if (a && l) return m_last ? 1 : 2;
        return l ? 2 : 1;
`else
        return l ? 2 : 1;
`endif
    endfunction

    task automatic cycle(input logic rst, input logic clr,
                         input logic av, input logic [RW-1:0] ai, input logic [31:0] avl,
                         input logic lv, input logic [RW-1:0] li, input logic [31:0] lvl);
        logic   ar, lr;
        int     g;
        entry_t e;
        resetIn = rst; clear = clr;
        aluValid = av; aluRobIndex = ai; aluValue = avl;
        lsbValid = lv; lsbRobIndex = li; lsbValue = lvl;
        #1;
        ar = !rst && !clr && (alu_q.size() < DEPTH);
        lr = !rst && !clr && (lsb_q.size() < DEPTH);
        chk("alu_ready", 64'(aluReady), 64'(ar));
        chk("lsb_ready", 64'(lsbReady), 64'(lr));
        if (rst) begin
            alu_q.delete(); lsb_q.delete();
            exp_valid = 1'b0; exp_rob = '0; exp_val = '0; m_last = 1'b1;
        end else if (clr) begin
            alu_q.delete(); lsb_q.delete();
            exp_valid = 1'b0; m_last = 1'b1;
        end else begin
            g = pick();
            exp_valid = (g != 0);
            if (g == 1) begin
                e = alu_q.pop_front(); exp_rob = e.rob; exp_val = e.val; m_last = 1'b0;
            end else if (g == 2) begin
                e = lsb_q.pop_front(); exp_rob = e.rob; exp_val = e.val; m_last = 1'b1;
            end
            if (av && ar) alu_q.push_back('{rob: ai, val: avl});
            if (lv && lr) lsb_q.push_back('{rob: li, val: lvl});
        end
        @(posedge clockIn);
        #1;
        chk("cdb_valid", 64'(cdbValid), 64'(exp_valid));
        chk("cdb_rob", 64'(cdbRobIndex), 64'(exp_rob));
        chk("cdb_val", 64'(cdbValue), 64'(exp_val));
    endtask

    task automatic idle();
        cycle(0, 0, 0, '0, '0, 0, '0, '0);
    endtask

    task automatic do_reset();
        cycle(1, 0, 0, '0, '0, 0, '0, '0);
    endtask

    logic [RW-1:0] order [4];
    logic [RW-1:0] exp_order [4];
    logic [RW-1:0] wrap_tags [5];

    initial begin
        do_reset();
        do_reset();
        chk("reset_cdb_rob", 64'(cdbRobIndex), 64'h0);

        // Single ALU entry: one-edge queueing, one-cycle pulse.
        cycle(0, 0, 1, 4'd3, 32'h11, 0, '0, '0);
        chk("first_push_no_bypass", 64'(cdbValid), 64'h0);
        idle();
        chk("first_bcast_rob", 64'(cdbRobIndex), 64'h3);
        chk("first_bcast_val", 64'(cdbValue), 64'h11);
        idle();
        chk("first_bcast_pulse_end", 64'(cdbValid), 64'h0);

        // Two entries per source: policy-dependent order.
        do_reset();
        cycle(0, 0, 1, 4'd1, 32'hA1, 1, 4'd5, 32'hB5);
        cycle(0, 0, 1, 4'd2, 32'hA2, 1, 4'd6, 32'hB6);
        order[0] = cdbRobIndex;
        for (int i = 1; i < 4; i++) begin
            idle();
            order[i] = cdbRobIndex;
        end
`ifdef CDB_ROUND_ROBIN_EN
        exp_order[0] = 4'd1; exp_order[1] = 4'd5; exp_order[2] = 4'd2; exp_order[3] = 4'd6;
`else
        exp_order[0] = 4'd5; exp_order[1] = 4'd6; exp_order[2] = 4'd1; exp_order[3] = 4'd2;
`endif
        for (int i = 0; i < 4; i++) chk("bcast_order", 64'(order[i]), 64'(exp_order[i]));
        idle();

        // LSB flood with ALU held valid.
        do_reset();
        for (int i = 0; i < 4; i++)
            cycle(0, 0, 1, RW'(8 + i), 32'hC0 + i, 1, RW'(i), 32'hD0 + i);
        repeat (6) idle();

        // Fill, then clear while an ALU offer is present.
        do_reset();
        for (int i = 0; i < 3; i++)
            cycle(0, 0, 1, RW'(i), 32'hE0 + i, 1, RW'(4 + i), 32'hF0 + i);
        cycle(0, 1, 1, 4'd9, 32'h99, 0, '0, '0);
        chk("clear_drops_valid", 64'(cdbValid), 64'h0);
        repeat (3) idle();

        // Pointer wrap with tags crossing the ROB index boundary.
        do_reset();
        wrap_tags[0] = 4'd14; wrap_tags[1] = 4'd15; wrap_tags[2] = 4'd0;
        wrap_tags[3] = 4'd1;  wrap_tags[4] = 4'd2;
        for (int i = 0; i < 5; i++) cycle(0, 0, 1, wrap_tags[i], 32'h500 + i, 0, '0, '0);
        repeat (3) idle();

        // Reset with one entry queued and one on the bus.
        do_reset();
        cycle(0, 0, 1, 4'd7, 32'h77, 0, '0, '0);
        cycle(0, 0, 1, 4'd8, 32'h88, 0, '0, '0);
        do_reset();
        chk("midreset_valid", 64'(cdbValid), 64'h0);
        chk("midreset_value", 64'(cdbValue), 64'h0);
        repeat (3) idle();

        // Random traffic.
        for (int i = 0; i < 1500; i++) begin
            cycle(($urandom_range(0, 79) == 0), ($urandom_range(0, 39) == 0),
                  ($urandom_range(0, 9) < 6), RW'($urandom), $urandom,
                  ($urandom_range(0, 9) < 6), RW'($urandom), $urandom);
        end
        repeat (4) idle();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
